// File: rtl/doa_peak_search.sv
// DoA angle scan: steps the steering index, settles, captures, tracks peak power.
// Optional DOA_THRESHOLD_EN adds a threshold port that qualifies peak_found.
module doa_peak_search #(
  parameter int WORD_LENGTH_IN = 71,
  parameter int N_ANGLES       = 181,
  parameter int ANGLE_W        = 8,
  parameter int SETTLE_SAMPLES = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      start,
  input  logic [WORD_LENGTH_IN-1:0] power_in,
  input  logic                      power_valid,
`ifdef DOA_THRESHOLD_EN
  input  logic [WORD_LENGTH_IN-1:0] threshold,
`endif
  output logic [ANGLE_W-1:0]        angle_idx,
  output logic                      busy,
  output logic                      done,
  output logic [ANGLE_W-1:0]        peak_angle,
  output logic [WORD_LENGTH_IN-1:0] peak_power,
  output logic                      peak_found
);

  localparam int CNT_W =
    (SETTLE_SAMPLES > 1) ? $clog2(SETTLE_SAMPLES) : 1;
  localparam int CNT_LAST_I =
    (SETTLE_SAMPLES > 0) ? SETTLE_SAMPLES - 1 : 0;
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(CNT_LAST_I);
  localparam logic [ANGLE_W-1:0] ANGLE_LAST = ANGLE_W'(N_ANGLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CAPTURE,
    FINISH
  } state_t;

  state_t                    state_q, state_d;
  logic [ANGLE_W-1:0]        angle_q, angle_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [WORD_LENGTH_IN-1:0] best_pwr_q, best_pwr_d;
  logic [ANGLE_W-1:0]        best_idx_q, best_idx_d;
  logic                      first_q, first_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [ANGLE_W-1:0]        pk_ang_q, pk_ang_d;
  logic [WORD_LENGTH_IN-1:0] pk_pwr_q, pk_pwr_d;
  logic                      pk_fnd_q, pk_fnd_d;
  logic                      found;

`ifdef DOA_THRESHOLD_EN
  logic [WORD_LENGTH_IN-1:0] thr_q, thr_d;
  assign found = best_pwr_q > thr_q;
`else
  assign found = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    angle_d    = angle_q;
    cnt_d      = cnt_q;
    best_pwr_d = best_pwr_q;
    best_idx_d = best_idx_q;
    first_d    = first_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pk_ang_d   = pk_ang_q;
    pk_pwr_d   = pk_pwr_q;
    pk_fnd_d   = pk_fnd_q;
`ifdef DOA_THRESHOLD_EN
    thr_d      = thr_q;
`endif
    unique case (state_q)
      IDLE: begin
        // done still high means FINISH just retired; skip that start
        if (start && !done_q) begin
          state_d    = SETTLE;
          angle_d    = '0;
          cnt_d      = '0;
          best_pwr_d = '0;
          best_idx_d = '0;
          first_d    = 1'b1;
          busy_d     = 1'b1;
`ifdef DOA_THRESHOLD_EN
          thr_d      = threshold;
`endif
        end
      end
      SETTLE: begin
        if (SETTLE_SAMPLES == 0) begin
          state_d = CAPTURE;
        end else if (power_valid) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = CAPTURE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      CAPTURE: begin
        if (power_valid) begin
          if (first_q || (power_in > best_pwr_q)) begin
            best_pwr_d = power_in;
            best_idx_d = angle_q;
          end
          first_d = 1'b0;
          if (angle_q == ANGLE_LAST) begin
            state_d = FINISH;
          end else begin
            angle_d = angle_q + ANGLE_W'(1);
            cnt_d   = '0;
            state_d = SETTLE;
          end
        end
      end
      FINISH: begin
        pk_ang_d = best_idx_q;
        pk_pwr_d = best_pwr_q;
        pk_fnd_d = found;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      angle_q    <= '0;
      cnt_q      <= '0;
      best_pwr_q <= '0;
      best_idx_q <= '0;
      first_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pk_ang_q   <= '0;
      pk_pwr_q   <= '0;
      pk_fnd_q   <= 1'b0;
`ifdef DOA_THRESHOLD_EN
      thr_q      <= '0;
`endif
    end else if (en) begin
      state_q    <= state_d;
      angle_q    <= angle_d;
      cnt_q      <= cnt_d;
      best_pwr_q <= best_pwr_d;
      best_idx_q <= best_idx_d;
      first_q    <= first_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pk_ang_q   <= pk_ang_d;
      pk_pwr_q   <= pk_pwr_d;
      pk_fnd_q   <= pk_fnd_d;
`ifdef DOA_THRESHOLD_EN
      thr_q      <= thr_d;
`endif
    end
  end

  assign angle_idx  = angle_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign peak_angle = pk_ang_q;
  assign peak_power = pk_pwr_q;
  assign peak_found = pk_fnd_q;

endmodule

// File: tb/tb_doa_peak_search.sv
// Directed bench for doa_peak_search (N_ANGLES=4, SETTLE_SAMPLES=2).
// Settle samples carry all-ones so a mistimed capture corrupts the peak.
module tb_doa_peak_search;

  localparam int W  = 71;
  localparam int NA = 4;
  localparam int AW = 8;
  localparam int S  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          start;
  logic [W-1:0]  power_in;
  logic          power_valid;
  logic [AW-1:0] angle_idx;
  logic          busy;
  logic          done;
  logic [AW-1:0] peak_angle;
  logic [W-1:0]  peak_power;
  logic          peak_found;
`ifdef DOA_THRESHOLD_EN
  logic [W-1:0]  threshold;
`endif

  int n_chk = 0;
  int n_err = 0;

  logic [W-1:0]  pw [NA];
  logic [AW-1:0] prev_ang;
  logic [W-1:0]  prev_pwr;
  logic [W-1:0]  big;

  doa_peak_search #(
    .WORD_LENGTH_IN (W),
    .N_ANGLES       (NA),
    .ANGLE_W        (AW),
    .SETTLE_SAMPLES (S)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .start       (start),
    .power_in    (power_in),
    .power_valid (power_valid),
`ifdef DOA_THRESHOLD_EN
    .threshold   (threshold),
`endif
    .angle_idx   (angle_idx),
    .busy        (busy),
    .done        (done),
    .peak_angle  (peak_angle),
    .peak_power  (peak_power),
    .peak_found  (peak_found)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_scan(input int gap, input bit hole, input bit spam,
                          input int exp_lat, input logic [AW-1:0] ea,
                          input logic [W-1:0] ep, input logic ef);
    int cyc;
    int v;
    bit seen;
    @(negedge clk);
    en = 1'b1;
    start = 1'b1;
    power_valid = 1'b0;
    @(posedge clk);
    #1;
    cyc = 1;
    v = 0;
    seen = 1'b0;
    check("busy_rise", busy, 1);
    check("idx_start", angle_idx, 0);
    while (cyc < 400 && !seen) begin
      @(negedge clk);
      start = spam && (cyc % 4 == 0);
      en = !(hole && cyc >= 4 && cyc <= 8);
      power_valid = en && (cyc % gap == 0) && (v < NA * (S + 1));
      power_in = '1;
      if (power_valid) begin
        if (v % (S + 1) == S) begin
          power_in = pw[v / (S + 1)];
          check("cap_idx", angle_idx, v / (S + 1));
        end
        v++;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 3) check("peak_hold", peak_power, prev_pwr);
      if (done) seen = 1'b1;
    end
    check("done_seen", seen, 1);
    check("latency", cyc, exp_lat);
    check("peak_angle", peak_angle, ea);
    check("peak_power", peak_power, ep);
    check("peak_found", peak_found, ef);
    check("busy_fall", busy, 0);
    @(negedge clk);
    en = 1'b1;
    start = 1'b1;
    power_valid = 1'b0;
    @(posedge clk);
    #1;
    check("done_pulse", done, 0);
    check("start_on_done", busy, 0);
    start = 1'b0;
    prev_ang = ea;
    prev_pwr = ep;
  endtask

  initial begin
    rst = 1'b0;
    en = 1'b1;
    start = 1'b0;
    power_in = '0;
    power_valid = 1'b0;
`ifdef DOA_THRESHOLD_EN
    threshold = '0;
`endif
    prev_ang = '0;
    prev_pwr = '0;
    big = '0;
    big[70] = 1'b1;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_idx", angle_idx, 0);
    check("rst_pang", peak_angle, 0);
    check("rst_ppwr", peak_power, 0);
    check("rst_pfnd", peak_found, 0);
    @(negedge clk);
    rst = 1'b1;

    pw[0] = 10; pw[1] = 50; pw[2] = 30; pw[3] = 20;
    run_scan(1, 1'b0, 1'b0, 14, 1, 50, 1'b1);

    pw[0] = 0; pw[1] = 0; pw[2] = 0; pw[3] = 0;
    run_scan(1, 1'b0, 1'b0, 14, 0, 0, 1'b1);

    pw[0] = 7; pw[1] = 9; pw[2] = 9; pw[3] = 3;
    run_scan(1, 1'b0, 1'b0, 14, 1, 9, 1'b1);

    pw[0] = 10; pw[1] = 50; pw[2] = 30; pw[3] = 20;
    run_scan(3, 1'b1, 1'b1, 41, 1, 50, 1'b1);

    pw[0] = 5; pw[1] = 3; pw[2] = big; pw[3] = big + W'(1);
    run_scan(1, 1'b0, 1'b0, 14, 3, big + W'(1), 1'b1);

    @(negedge clk);
    start = 1'b1;
    power_valid = 1'b1;
    power_in = '1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_idx", angle_idx, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_pang", peak_angle, 0);
    check("mid_rst_ppwr", peak_power, 0);
    check("mid_rst_pfnd", peak_found, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("mid_rst_nodone", done, 0);
    end
    @(negedge clk);
    rst = 1'b1;
    power_valid = 1'b0;
    prev_ang = '0;
    prev_pwr = '0;

    pw[0] = 10; pw[1] = 50; pw[2] = 30; pw[3] = 20;
    run_scan(1, 1'b0, 1'b0, 14, 1, 50, 1'b1);

`ifdef DOA_THRESHOLD_EN
    threshold = 49;
    run_scan(1, 1'b0, 1'b0, 14, 1, 50, 1'b1);
    threshold = 50;
    run_scan(1, 1'b0, 1'b0, 14, 1, 50, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
